// File: rtl/adc_sched_pkg.sv
// Shared defaults, FSM state type and channel-slice helper for the ADC scan scheduler.
package adc_sched_pkg;

  localparam int unsigned NUM_CH          = 8;
  localparam int unsigned RES_W           = 12;
  localparam int unsigned DEF_PERIOD_W    = 24;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;
  localparam int unsigned AVG_LOG2        = 2;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned DATA_W          = NUM_CH * RES_W;
  localparam int unsigned DATA_IDX_W      = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_CONV,
    ST_CAPTURE
  } state_e;

  // Extract channel ch from the flat ADC data word.
  function automatic logic [RES_W-1:0] ch_slice(input logic [DATA_W-1:0] data,
                                                input int unsigned       ch);
    logic [DATA_IDX_W-1:0] lsb;
    lsb = DATA_IDX_W'(RES_W * ch);
    return data[lsb +: RES_W];
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Free-running scan-period counter; tick_c requests a scan every `period_i` cycles while enabled.
module adc_period_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_c
);

  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W:0]   next_c;

  // A period of 0 satisfies the compare every cycle, giving back-to-back requests.
  always_comb begin
    timer_d = timer_q;
    tick_c  = 1'b0;
    next_c  = {1'b0, timer_q} + (PERIOD_W+1)'(1);
    if (!enable_i) begin
      timer_d = '0;
    end else if (next_c >= {1'b0, period_i}) begin
      tick_c  = 1'b1;
      timer_d = '0;
    end else begin
      timer_d = PERIOD_W'(next_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Sequences periodic / one-shot scans of the 8-channel serial ADC and publishes masked results.
// Optional macro ADC_AVG_EN: publish the average of 2^AVG_LOG2 scans instead of every scan.
module adc_scan_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned PERIOD_W    = DEF_PERIOD_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    trigger,
  input  logic [PERIOD_W-1:0]     period,
  input  logic [NUM_CH-1:0]       ch_mask,
  output logic                    adc_start,
  input  logic                    adc_ready,
  input  logic [NUM_CH*RES_W-1:0] adc_data,
  input  logic [2:0]              rd_ch,
  output logic [RES_W-1:0]        rd_data,
  output logic                    busy,
  output logic                    scan_done,
  output logic [CNT_W-1:0]        scan_count,
  output logic                    err_timeout
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e                       state_q, state_d;
  logic [TMO_W-1:0]             wait_q, wait_d;
  logic                         pending_q, pending_d;
  logic                         adc_start_q, busy_q, scan_done_q, err_q, enable_q;
  logic [CNT_W-1:0]             scan_count_q;
  logic [RES_W-1:0]             rd_data_q;
  logic [NUM_CH-1:0][RES_W-1:0] result_q;
  logic                         tick_c, timeout_c, capture_c, publish_c, enter_req_c;

  adc_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .period_i (period),
    .tick_c   (tick_c)
  );

  assign capture_c = (state_q == ST_CAPTURE);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q + 1'b1;
    timeout_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (pending_q && adc_ready) state_d = ST_REQ;
      ST_REQ: begin
        if (!adc_ready) begin
          state_d = ST_CONV;
        end else if (wait_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (adc_ready) begin
          state_d = ST_CAPTURE;
        end else if (wait_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (state_d != state_q) wait_d = '0;
    // A request arriving on the REQ-entry cycle must survive the clear.
    enter_req_c = (state_q == ST_IDLE) && (state_d == ST_REQ);
    pending_d   = (pending_q && !enter_req_c) || trigger || tick_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      pending_q    <= 1'b0;
      adc_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      scan_done_q  <= 1'b0;
      err_q        <= 1'b0;
      enable_q     <= 1'b0;
      scan_count_q <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      pending_q   <= pending_d;
      adc_start_q <= (state_d == ST_REQ);
      busy_q      <= (state_d != ST_IDLE);
      scan_done_q <= publish_c;
      enable_q    <= enable;
      if (publish_c) scan_count_q <= scan_count_q + 16'd1;
      if (timeout_c)                err_q <= 1'b1;
      else if (enable && !enable_q) err_q <= 1'b0;
      rd_data_q <= result_q[rd_ch];
    end
  end

`ifdef ADC_AVG_EN
  localparam int unsigned ACC_W = RES_W + AVG_LOG2;

  logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_sum_c;
  logic [AVG_LOG2-1:0]          avg_cnt_q;
  logic                         last_c;

  assign last_c    = &avg_cnt_q;
  assign publish_c = capture_c && last_c;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      acc_sum_c[i] = acc_q[i] + (ch_mask[i] ? ACC_W'(ch_slice(adc_data, i)) : ACC_W'(0));
    end
  end

  // Timeout discards the partially accumulated window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
      result_q  <= '0;
    end else if (timeout_c) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else if (capture_c) begin
      avg_cnt_q <= avg_cnt_q + 1'b1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (last_c) begin
          acc_q[i] <= '0;
          if (ch_mask[i]) result_q[i] <= RES_W'(acc_sum_c[i] >> AVG_LOG2);
        end else begin
          acc_q[i] <= acc_sum_c[i];
        end
      end
    end
  end
`else
  assign publish_c = capture_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (capture_c) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_mask[i]) result_q[i] <= ch_slice(adc_data, i);
      end
    end
  end
`endif

  assign adc_start   = adc_start_q;
  assign busy        = busy_q;
  assign scan_done   = scan_done_q;
  assign scan_count  = scan_count_q;
  assign err_timeout = err_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scoreboard bench for adc_scan_scheduler: expected scans queued at stimulus, checked on scan_done.
module tb_adc_scan_scheduler;
  import adc_sched_pkg::*;

  typedef struct packed {
    logic [15:0]                  cnt;
    logic [NUM_CH-1:0][RES_W-1:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, enable, trigger, adc_start, adc_ready, busy, scan_done, err_timeout;
  logic [23:0] period;
  logic [7:0]  ch_mask;
  logic [95:0] adc_data;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic [15:0] scan_count;

  int   n_chk = 0, n_pass = 0, cyc = 0;
  exp_t exp_q[$];
  int   start_times[$], done_times[$];
  logic [NUM_CH-1:0][RES_W-1:0] model_res;
  logic [15:0] model_cnt;
  logic        mon_busy, adc_hang, start_prev;

  adc_scan_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger), .period(period),
    .ch_mask(ch_mask), .adc_start(adc_start), .adc_ready(adc_ready), .adc_data(adc_data),
    .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy), .scan_done(scan_done),
    .scan_count(scan_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ADC model: ready drops the cycle after a start is seen and stays low for 20 cycles.
  initial begin
    adc_ready = 1'b1;
    forever begin
      @(posedge clk);
      if (adc_start === 1'b1 && !adc_hang) begin
        #1 adc_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 adc_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    start_prev <= adc_start;
    if (adc_start === 1'b1 && start_prev !== 1'b1) start_times.push_back(cyc);
  end

  // Monitor: on every scan_done pop an expectation and sweep all read channels.
  initial begin
    exp_t e;
    rd_ch    = 3'd0;
    mon_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (scan_done === 1'b1) begin
        done_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("extra_scan_done", 32'(scan_done), 32'd0);
        end else begin
          mon_busy = 1'b1;
          e = exp_q.pop_front();
          chk("scan_count", 32'(scan_count), 32'(e.cnt));
          for (int ch = 0; ch < NUM_CH; ch++) begin
            rd_ch = 3'(ch);
            @(negedge clk);
            chk($sformatf("rd_data[%0d]", ch), 32'(rd_data), 32'(e.res[3'(ch)]));
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic push_scan(input logic [7:0] m, input logic [95:0] d);
    exp_t e;
    for (int i = 0; i < NUM_CH; i++)
      if (m[i]) model_res[3'(i)] = 12'(d >> (12 * i));
    model_cnt = model_cnt + 16'd1;
    e.cnt = model_cnt;
    e.res = model_res;
    exp_q.push_back(e);
  endtask

  task automatic pulse_trigger();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
  endtask

  task automatic wait_drained(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin @(negedge clk); n++; end
    chk({name, "_pending_scans"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ready(input logic lvl, input string name);
    int n = 0;
    while (adc_ready !== lvl && n < 200) begin @(negedge clk); n++; end
    chk(name, 32'(adc_ready), 32'(lvl));
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    model_res = '0;
    model_cnt = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, d0, n;
    rst_n = 1'b0; enable = 1'b0; trigger = 1'b0; period = 24'd100;
    ch_mask = 8'hFF; adc_data = '0; adc_hang = 1'b0;
    model_res = '0; model_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_adc_start", 32'(adc_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_scan_count", 32'(scan_count), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;

`ifdef ADC_AVG_EN
    begin
      exp_t e;
      e.cnt = 16'd1;
      e.res = {NUM_CH{12'd25}};
      exp_q.push_back(e);
    end
    foreach (start_times[i]) start_times[i] = 0;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: adc_data = {NUM_CH{12'd10}};
        1: adc_data = {NUM_CH{12'd20}};
        2: adc_data = {NUM_CH{12'd30}};
        default: adc_data = {NUM_CH{12'd41}};
      endcase
      pulse_trigger();
      wait_ready(1'b0, "avg_conv");
      wait_ready(1'b1, "avg_done");
      repeat (4) @(negedge clk);
    end
    wait_drained(100, "avg");
    chk("avg_done_count", 32'(done_times.size()), 32'd1);
`else
    // Periodic scanning every 100 cycles, full mask.
    adc_data = {NUM_CH{12'hFFF}};
    repeat (3) push_scan(8'hFF, adc_data);
    s0 = start_times.size();
    d0 = done_times.size();
    enable = 1'b1;
    wait_drained(1000, "periodic");
    enable = 1'b0;
    chk("periodic_starts", 32'(start_times.size() - s0), 32'd3);
    if (start_times.size() - s0 >= 3 && done_times.size() - d0 >= 1) begin
      chk("period_gap1", 32'(start_times[s0+1] - start_times[s0]), 32'd100);
      chk("period_gap2", 32'(start_times[s0+2] - start_times[s0+1]), 32'd100);
      chk("start_to_done", 32'(done_times[d0] - start_times[s0]), 32'd23);
    end

    // One-shot scan with a sparse channel mask after reset.
    do_reset();
    for (int i = 0; i < NUM_CH; i++) adc_data[i*12 +: 12] = 12'h100 + 12'(i);
    ch_mask = 8'h05;
    push_scan(ch_mask, adc_data);
    pulse_trigger();
    wait_drained(200, "mask");

    // Triggers in CONV and CAPTURE collapse into one immediate follow-up scan.
    ch_mask  = 8'hFF;
    adc_data = {NUM_CH{12'h2A5}};
    push_scan(ch_mask, adc_data);
    push_scan(ch_mask, adc_data);
    s0 = start_times.size();
    d0 = done_times.size();
    pulse_trigger();
    wait_ready(1'b0, "retrig_conv");
    pulse_trigger();
    wait_ready(1'b1, "retrig_conv_end");
    @(negedge clk);
    chk("capture_busy", 32'(busy), 32'd1);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk("done_after_capture", 32'(scan_done), 32'd1);
    wait_drained(300, "retrigger");
    repeat (150) @(negedge clk);
    chk("retrigger_scans", 32'(done_times.size() - d0), 32'd2);
    if (start_times.size() - s0 >= 2 && done_times.size() - d0 >= 1)
      chk("restart_gap", 32'(start_times[s0+1] - done_times[d0]), 32'd1);

    // Asynchronous reset in the middle of a conversion.
    pulse_trigger();
    wait_ready(1'b0, "rst_conv");
    repeat (3) @(negedge clk);
    chk("conv_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_adc_start", 32'(adc_start), 32'd0);
    chk("arst_scan_count", 32'(scan_count), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_scan_done", 32'(scan_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_res = '0;
    model_cnt = '0;
    wait_ready(1'b1, "arst_adc_idle");
    adc_data = {NUM_CH{12'h3C3}};
    push_scan(ch_mask, adc_data);
    pulse_trigger();
    wait_drained(200, "post_reset");

    // ADC never acknowledges: REQ times out after 4096 cycles.
    adc_hang = 1'b1;
    period   = 24'd1000;
    pulse_trigger();
    n = 0;
    while (adc_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("timeout_req_entry", 32'(adc_start), 32'd1);
    n = 0;
    while (adc_start === 1'b1 && n < 5000) begin n++; @(negedge clk); end
    chk("timeout_req_cycles", 32'(n), 32'd4096);
    chk("timeout_err", 32'(err_timeout), 32'd1);
    chk("timeout_idle", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("timeout_no_retry", 32'(busy), 32'd0);
    chk("timeout_sticky", 32'(err_timeout), 32'd1);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(err_timeout), 32'd0);
    adc_hang = 1'b0;
    push_scan(ch_mask, adc_data);
    pulse_trigger();
    wait_drained(200, "after_timeout");
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
